ula_kb_pad_bank: RTL
====================

# ula_kb_pad_bank

Parametrised bank of keyboard pad channels with per-channel synchroniser, programmable debounce, self-drive blanking and a sticky change-report handshake. Sits between the KB pads and the ULA port-read logic. It replaces per-bit raw keyboard pad instances: the CPU read path sees clean, glitch-free levels, and firmware polls or acks a change mask.

## Interface
Parameters:
- WIDTH, 5, number of keyboard channels.
- CNT_W, 8, width of debounce counter and `db_period`.
- SYNC_STAGES, 2, synchroniser flops per channel; legal range 2..4.

Ports:
- clk  in  1  sole clock, all state on rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- pad  inout  WIDTH  keyboard pads, externally pulled up; open-drain drive only.
- drive_low  in  WIDTH  bit i = 1 drives pad[i] to 0, else Z.
- db_period  in  CNT_W  debounce threshold P in cycles; 0 = no debounce; sampled every cycle.
- kb_level  out  WIDTH  debounced pad levels.
- change_mask  out  WIDTH  sticky per-channel "debounced level changed" flags.
- changed  out  1  OR of change_mask.
- ack  in  1  one-cycle pulse; clears flags reported.

## Operation
- Pad drive: pad[i] = 0 when drive_low[i] = 1 and n_reset = 1, else Z. This is combinational, not registered.
- Synchroniser: SYNC_STAGES flops per channel. Its output is s[i].
- Debounce, per channel, each edge, in priority order:
  - If blank[i] ≠ 0: cnt is held at 0 and kb_level is unchanged.
  - Else if s == kb_level: cnt <= 0.
  - Else if cnt >= db_period: kb_level <= s, cnt <= 0, and change_mask[i] is set.
  - Else: cnt <= cnt + 1.
- `>=` is required so that lowering db_period mid-count takes effect at once. cnt never wraps.
- Blanking: while drive_low[i] = 1, blank[i] loads SYNC_STAGES+1. After release it counts down by 1 per edge to 0. This stops the channel's own drive from registering as a keypress.
- Handshake:
  - On ack, change_mask <= set_this_cycle. Bits set in the ack cycle survive; all other bits clear.
  - When ack = 0, bits only accumulate.
  - ack with mask = 0 is a no-op.
- Reset values: sync flops = 1, kb_level = all 1, cnt = 0, blank = 0, change_mask = 0, changed = 0, pad = Z.
- Reset mid-debounce discards the count; no flag is raised on reset exit.

## Timing
- Pad-to-kb_level latency is SYNC_STAGES + 1 + P edges after the first edge that samples the new level, provided the level holds.
  - Defaults with P = 0: 3 cycles.
  - Defaults with P = 4: 7 cycles.
- A pulse on s shorter than P+1 cycles produces no kb_level change and no flag. Each return of s to kb_level restarts the count.
- change_mask and changed rise in the same cycle that kb_level updates. changed is combinational from the mask register.
- ack takes effect on the edge where it is high; mask reads 0 the next cycle unless a new set occurred.
- The blank window ends SYNC_STAGES+1 edges after the falling edge of drive_low[i].
- Channels are fully independent. Simultaneous transitions on several channels set all their bits on the same edge.

## Structure
- Package ula_kb_pkg holds:
  - the reset/idle level constant (1'b1);
  - the SYNC_STAGES legality bounds;
  - the blank-length function (SYNC_STAGES+1).
- Sub-module ula_kb_channel contains synchroniser, cnt, blank and kb_level for one bit, plus a set_pulse output. It is instantiated WIDTH times by generate.
- The top level holds change_mask/ack logic and the tri-state pad assigns.

## Test plan
- Reset, pads pulled high:
  - kb_level = 5'b11111, change_mask = 0, changed = 0, all pads Z.
- P = 4, pad[2] forced 0 and held:
  - kb_level[2] falls exactly 7 cycles after the first sampling edge;
  - change_mask = 5'b00100 and changed = 1 in the same cycle.
- P = 4, glitches on pad[0]:
  - a 4-cycle low glitch gives no change;
  - a 5-cycle low gives kb_level[0] = 0.
- drive_low[1] high for 10 cycles, pad[1] reads 0:
  - kb_level[1] stays 1 and mask stays 0;
  - after release plus 3 cycles, the channel debounces normally again.
- mask = 5'b00100, pad[3] completes debounce in the same cycle as ack:
  - next mask = 5'b01000.
- n_reset asserted mid-count on pad[4]:
  - cnt cleared and kb_level[4] = 1;
  - after release, a full SYNC_STAGES+1+P delay is required before kb_level[4] changes.

Source files
------------

// File: rtl/ula_kb_pkg.sv
// Shared constants and helpers for the keyboard pad bank: idle level,
// synchroniser depth bounds and the self-drive blanking length.
package ula_kb_pkg;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   SYNC_MIN   = 2;
    localparam int   SYNC_MAX   = 4;
    localparam int   BLANK_W    = 3;

    // Blanking must outlast the synchroniser plus one evaluation edge.
    function automatic logic [BLANK_W-1:0] blank_len(input int stages);
        return BLANK_W'(stages + 1);
    endfunction

endpackage

// File: rtl/ula_kb_channel.sv
// One keyboard channel: synchroniser, self-drive blanking and debounce.
// set_pulse is high in the cycle whose closing edge updates kb_level.
module ula_kb_channel
    import ula_kb_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             pad_in,
    input  logic             drive_low,
    input  logic [CNT_W-1:0] db_period,
    output logic             kb_level,
    output logic             set_pulse
);

    localparam int SYNC_N = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN :
                            ((SYNC_STAGES > SYNC_MAX) ? SYNC_MAX : SYNC_STAGES);

    logic [SYNC_N-1:0]  sync_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic [BLANK_W-1:0] blank_r;
    logic [BLANK_W-1:0] blank_next_s;
    logic               kb_level_r;
    logic               kb_next_s;
    logic               set_s;
    logic               sync_s;

    assign sync_s = sync_r[SYNC_N-1];

    // Debounce decision; >= lets a lowered threshold fire immediately.
    always_comb begin
        cnt_next_s = cnt_r;
        kb_next_s  = kb_level_r;
        set_s      = 1'b0;
        if (blank_r != '0) begin
            cnt_next_s = '0;
        end else if (sync_s == kb_level_r) begin
            cnt_next_s = '0;
        end else if (cnt_r >= db_period) begin
            kb_next_s  = sync_s;
            cnt_next_s = '0;
            set_s      = 1'b1;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Blank window reloads while driving and drains after release.
    always_comb begin
        blank_next_s = blank_r;
        if (drive_low) begin
            blank_next_s = blank_len(SYNC_N);
        end else if (blank_r != '0) begin
            blank_next_s = blank_r - BLANK_W'(1);
        end else begin
            blank_next_s = '0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync_r     <= {SYNC_N{IDLE_LEVEL}};
            cnt_r      <= '0;
            blank_r    <= '0;
            kb_level_r <= IDLE_LEVEL;
        end else begin
            sync_r     <= {sync_r[SYNC_N-2:0], pad_in};
            cnt_r      <= cnt_next_s;
            blank_r    <= blank_next_s;
            kb_level_r <= kb_next_s;
        end
    end

    assign kb_level  = kb_level_r;
    assign set_pulse = set_s;

endmodule

// File: rtl/ula_kb_pad_bank.sv
// Bank of debounced keyboard pad channels with open-drain self-drive and a
// sticky change mask that firmware acknowledges.
module ula_kb_pad_bank
    import ula_kb_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             n_reset,
    inout  wire  [WIDTH-1:0] pad,
    input  logic [WIDTH-1:0] drive_low,
    input  logic [CNT_W-1:0] db_period,
    output logic [WIDTH-1:0] kb_level,
    output logic [WIDTH-1:0] change_mask,
    output logic             changed,
    input  logic             ack
);

    logic [WIDTH-1:0] set_s;
    logic [WIDTH-1:0] change_mask_r;
    logic [WIDTH-1:0] mask_next_s;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        // Open-drain: only ever pull low, and never while in reset.
        assign pad[gi] = (drive_low[gi] && n_reset) ? 1'b0 : 1'bz;

        ula_kb_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk       (clk),
            .n_reset   (n_reset),
            .pad_in    (pad[gi]),
            .drive_low (drive_low[gi]),
            .db_period (db_period),
            .kb_level  (kb_level[gi]),
            .set_pulse (set_s[gi])
        );
    end

    // Ack replaces the mask with this cycle's sets so no new change is lost.
    always_comb begin
        mask_next_s = change_mask_r;
        if (ack) begin
            mask_next_s = set_s;
        end else begin
            mask_next_s = change_mask_r | set_s;
        end
    end

    // Sticky change mask register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            change_mask_r <= '0;
        end else begin
            change_mask_r <= mask_next_s;
        end
    end

    assign change_mask = change_mask_r;
    assign changed     = |change_mask_r;

endmodule
